input_debounce_pulse: RTL and testbench

//   Conditions the raw board inputs (push button Btn1, slide switches Sw) before they reach the

---
 rtl/input_debounce_pulse_pkg.sv | 9 +
 rtl/debounce_channel.sv | 51 +++++
 rtl/input_debounce_pulse.sv | 75 +++++++
 tb/tb_input_debounce_pulse.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/input_debounce_pulse_pkg.sv
// Shared constants for the input conditioning block: debounce windows and default channel count.
package input_debounce_pulse_pkg;

  localparam int unsigned DEBOUNCE_10MS = 1_000_000;  // 10 ms at 100 MHz
  localparam int unsigned DEBOUNCE_SIM  = 4;          // short window for simulation
  localparam int unsigned N_SW_DEFAULT  = 4;
  localparam int unsigned CNT_W_DEFAULT = 20;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser followed by a stability counter that only accepts a new
// level after it has been seen continuously for CNT_MAX cycles.
module debounce_channel #(
  parameter int unsigned CNT_MAX = 1_000_000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);

  logic             r_s0;
  logic             r_s1;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_stable_d;
  logic [CNT_W-1:0] w_cnt_d;

  // Any sample agreeing with the accepted level restarts the window, so glitches never accumulate.
  always_comb begin
    w_cnt_d    = '0;
    w_stable_d = r_stable;
    if (r_s1 != r_stable) begin
      if (r_cnt == CntLast) begin
        w_stable_d = r_s1;
      end else begin
        w_cnt_d = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0     <= 1'b0;
      r_s1     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s0     <= raw;
      r_s1     <= r_s0;
      r_stable <= w_stable_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign level = r_stable;

endmodule

// File: rtl/input_debounce_pulse.sv
// Debounces the push button and slide switches and derives registered edge pulses from the clean
// levels, so downstream logic can run entirely on CLK100MHZ.
module input_debounce_pulse
  import input_debounce_pulse_pkg::*;
#(
  parameter int unsigned CNT_MAX = DEBOUNCE_10MS,
  parameter int unsigned N_SW    = N_SW_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic            CLK100MHZ,
  input  logic            CPU_RESETN,
  input  logic            Btn1,
  input  logic [N_SW-1:0] Sw,
  output logic            btn_level,
  output logic            btn_pulse,
  output logic            btn_release,
  output logic [N_SW-1:0] sw_clean,
  output logic            sw_change
);

  logic            w_btn_stable;
  logic [N_SW-1:0] w_sw_stable;

  logic            r_btn_d;
  logic            r_btn_pulse;
  logic            r_btn_release;
  logic [N_SW-1:0] r_sw_d;
  logic            r_sw_change;

  debounce_channel #(
    .CNT_MAX (CNT_MAX),
    .CNT_W   (CNT_W)
  ) u_btn (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .raw   (Btn1),
    .level (w_btn_stable)
  );

  for (genvar g = 0; g < int'(N_SW); g++) begin : g_sw
    debounce_channel #(
      .CNT_MAX (CNT_MAX),
      .CNT_W   (CNT_W)
    ) u_sw (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .raw   (Sw[g]),
      .level (w_sw_stable[g])
    );
  end

  // Several switch bits accepted on the same edge collapse into one change pulse.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_btn_d       <= 1'b0;
      r_btn_pulse   <= 1'b0;
      r_btn_release <= 1'b0;
      r_sw_d        <= '0;
      r_sw_change   <= 1'b0;
    end else begin
      r_btn_d       <= w_btn_stable;
      r_btn_pulse   <= w_btn_stable & ~r_btn_d;
      r_btn_release <= ~w_btn_stable & r_btn_d;
      r_sw_d        <= w_sw_stable;
      r_sw_change   <= |(w_sw_stable ^ r_sw_d);
    end
  end

  assign btn_level   = w_btn_stable;
  assign btn_pulse   = r_btn_pulse;
  assign btn_release = r_btn_release;
  assign sw_clean    = w_sw_stable;
  assign sw_change   = r_sw_change;

endmodule

// File: tb/tb_input_debounce_pulse.sv
// Scoreboard bench: stimulus queues the expected pulse events (cycle and output snapshot) and a
// monitor pops and compares one entry every time the DUT raises any pulse output.
module tb_input_debounce_pulse;
  import input_debounce_pulse_pkg::*;

  localparam int unsigned NSw = 4;

  typedef struct packed {
    int         cyc;
    logic [7:0] v;  // {pulse, release, change, sw_clean[3:0], level}
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           btn;
  logic [NSw-1:0] sw;
  logic           btn_level;
  logic           btn_pulse;
  logic           btn_release;
  logic [NSw-1:0] sw_clean;
  logic           sw_change;

  int   cyc;
  int   total;
  int   bad;
  exp_t exp_q[$];

  input_debounce_pulse #(
    .CNT_MAX (DEBOUNCE_SIM),
    .N_SW    (NSw),
    .CNT_W   (20)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .Btn1        (btn),
    .Sw          (sw),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .btn_release (btn_release),
    .sw_clean    (sw_clean),
    .sw_change   (sw_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input logic p, input logic r, input logic ch,
                      input logic [3:0] s, input logic l);
    exp_t e;
    e.cyc = c;
    e.v   = {p, r, ch, s, l};
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the scoreboard in cycle and content.
  always @(negedge clk) begin
    if (rst_n && (btn_pulse || btn_release || sw_change)) begin
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got %b at cycle %0d expected none",
                 {btn_pulse, btn_release, sw_change, sw_clean, btn_level}, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v !== {btn_pulse, btn_release, sw_change, sw_clean, btn_level}) begin
          bad++;
          $display("FAIL pulse_event: got %b at cycle %0d expected %b at cycle %0d",
                   {btn_pulse, btn_release, sw_change, sw_clean, btn_level}, cyc, e.v, e.cyc);
        end
      end
    end
  end

  initial begin
    int  c;
    int  r;
    logic seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    btn   = 1'b0;
    sw    = '0;
    tick(3);
    check("reset_outputs", {btn_pulse, btn_release, sw_change, sw_clean, btn_level}, 8'h00);
    rst_n = 1'b1;
    tick(5);

    // 1: clean press held 20 cycles, then clean release
    c = cyc; btn = 1'b1;
    push(c + 7, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    tick(5);
    check("t1_level_edge5", {7'd0, btn_level}, 8'd0);
    tick(1);
    check("t1_level_edge6", {7'd0, btn_level}, 8'd1);
    tick(14);
    c = cyc; btn = 1'b0;
    push(c + 7, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    tick(12);

    // 2: 3-cycle pulse is rejected
    btn = 1'b1;
    tick(3);
    btn  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (btn_level || btn_pulse) seen = 1'b1;
    end
    check("t2_glitch_rejected", {7'd0, seen}, 8'd0);

    // 3: bouncy press and bouncy release, one pulse each
    btn = 1'b1; tick(1); btn = 1'b0; tick(1); btn = 1'b1; tick(1); btn = 1'b0; tick(1);
    c = cyc; btn = 1'b1;
    push(c + 7, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    tick(15);
    btn = 1'b0; tick(1); btn = 1'b1; tick(1); btn = 1'b0; tick(1); btn = 1'b1; tick(1);
    c = cyc; btn = 1'b0;
    push(c + 7, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    tick(15);

    // 4: switch steps
    c = cyc; sw = 4'b0100;
    push(c + 7, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0);
    tick(5);
    check("t4_sw_edge5", {4'd0, sw_clean}, 8'h00);
    tick(1);
    check("t4_sw_edge6", {4'd0, sw_clean}, 8'h04);
    tick(10);
    c = cyc; sw = 4'b1011;
    push(c + 7, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
    tick(15);
    check("t4_sw_1011", {4'd0, sw_clean}, 8'h0b);
    c = cyc; sw = 4'b0000;
    push(c + 7, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    tick(15);

    // 5: simultaneous button and switch acceptance
    c = cyc; btn = 1'b1; sw = 4'b0001;
    push(c + 7, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1);
    tick(15);
    c = cyc; btn = 1'b0; sw = 4'b0000;
    push(c + 7, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    tick(15);

    // 6: reset mid-count with the button held
    btn = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("t6_outputs_in_reset", {btn_pulse, btn_release, sw_change, sw_clean, btn_level}, 8'h00);
    tick(1);
    r = cyc; rst_n = 1'b1;
    push(r + 7, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    tick(5);
    check("t6_level_after5", {7'd0, btn_level}, 8'd0);
    tick(1);
    check("t6_level_after6", {7'd0, btn_level}, 8'd1);
    tick(14);
    c = cyc; btn = 1'b0;
    push(c + 7, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    tick(15);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses: got %0d events outstanding expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
